// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: state encodings and frame constants.
package inst_mem_loader_pkg;

  localparam int INST_W = 16;
  localparam int BYTE_W = 8;
  localparam int LEN_BYTES = 2;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_HI = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_DAT_HI = 4'd3;
  localparam logic [3:0] S_DAT_LO = 4'd4;
  localparam logic [3:0] S_WRITE  = 4'd5;
  localparam logic [3:0] S_CHK    = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  // States in which a byte may be taken from the host link.
  function automatic logic is_rx_state(input logic [3:0] s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) ||
           (s == S_DAT_LO) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/inst_mem_loader_if.sv
// Host byte stream in, instruction memory write port out.
interface inst_mem_loader_if #(
  parameter int ADDR_W = 16
);
  import inst_mem_loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_wraddress;
  logic [INST_W-1:0] mem_data;
  logic              mem_wren;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_wraddress, mem_data, mem_wren
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_wraddress, mem_data, mem_wren
  );

endinterface

// File: rtl/inst_mem_loader_timeout.sv
// Idle-cycle counter: counts enabled cycles since the last clear, saturating at TIMEOUT_CYC.
module inst_mem_loader_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed byte-stream program image into instruction memory, holding the CPU until done.
// Optional trailing mod-256 checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MAX_WORDS   = 65536,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  inst_mem_loader_if.slave  bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  logic [3:0]        state_q, state_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INST_W-1:0] data_q, data_d;
  logic [ADDR_W:0]   wl_q, wl_d;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum_q, sum_d;
`endif

  logic rx_ok, accept, start_go, expired;
  logic [15:0] len_rx;

  assign rx_ok    = is_rx_state(state_q);
  assign accept   = rx_ok && bus.rx_valid;
  assign start_go = start && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign len_rx   = {hi_q, bus.rx_data};

  inst_mem_loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept || start_go),
    .en      (rx_ok),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wl_d    = wl_q;
`ifdef INST_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          wl_d    = '0;
          addr_d  = '0;
`ifdef INST_LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN_HI: if (accept) begin
        hi_d    = bus.rx_data;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d = len_rx;
        if (len_rx == 16'd0)
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        else if ({16'd0, len_rx} > 32'(MAX_WORDS)) state_d = S_ERR;
        else                                       state_d = S_DAT_HI;
      end
      S_DAT_HI: if (accept) begin
        hi_d    = bus.rx_data;
        state_d = S_DAT_LO;
      end
      S_DAT_LO: if (accept) begin
        data_d  = len_rx;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // Address and count advance after the strobe cycle so the write sees the current index.
        addr_d = addr_q + 1'b1;
        wl_d   = wl_q + 1'b1;
        if ({{(31 - ADDR_W){1'b0}}, wl_q} + 32'd1 == {16'd0, len_q})
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        else
          state_d = S_DAT_HI;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK: if (accept) begin
        state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (rx_ok && !accept && expired) state_d = S_ERR;
`ifdef INST_LOADER_CHECKSUM_EN
    if (accept && (state_q != S_CHK)) sum_d = sum_q + bus.rx_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wl_q    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wl_q    <= wl_d;
`ifdef INST_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.rx_ready      = rx_ok;
  assign bus.mem_wren      = (state_q == S_WRITE);
  assign bus.mem_wraddress = addr_q;
  assign bus.mem_data      = data_q;
  assign cpu_hold          = (state_q != S_DONE);
  assign busy              = rx_ok || (state_q == S_WRITE);
  assign done              = (state_q == S_DONE);
  assign error             = (state_q == S_ERR);
  assign words_loaded      = wl_q;

endmodule
